seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Scan controller for the board's 8-digit multiplexed seven-segment display. It captures the 32-bit writeback result `ResultW` from the RISC-V pipeline on a load strobe and holds it in a shadow register. It then time-multiplexes the eight hex nibbles onto one shared segment bus with per-digit anode enables and an anti-ghosting blank gap. It sits between the pipeline's writeback stage and the FPGA display pins, and replaces the single-digit display path.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ `GAP_CYC`+1.
- `GAP_CYC`, 200: cycles at the start of each slot with all anodes off (anti-ghosting).
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `ResultW`  input  32  value to display; nibble k drives digit k (digit 0 = rightmost).
- `load`  input  1  single-cycle strobe; captures `ResultW` into the shadow register.
- `hold`  input  1  when high, the frame-boundary copy is suppressed and the shown value freezes.
- `anode`  output  8  digit enables, active-low, one-hot-low or all ones.
- `display`  output  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  output  1  decimal point, active-low; always 1 (off).
- `frame_start`  output  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Registers: `shadow[31:0]`, `shown[31:0]`, prescaler `cnt` (0..`REFRESH_DIV`-1), digit index `idx[2:0]`, state.
- States:
  - IDLE: after reset. Anodes off. Exits to SCAN on the first `load`, with `shown`=`shadow`=`ResultW`, `idx`=0 and `cnt`=0.
  - SCAN: runs forever until `rst`.
- `load` always updates `shadow`. Multiple loads within a frame keep only the last value.
- Frame boundary is the cycle with `cnt`=`REFRESH_DIV`-1 and `idx`=7. On that cycle, if `hold`=0, `shown` takes `load ? ResultW : shadow`, so a load on the boundary cycle bypasses to `shown`.
- On each slot end (`cnt`=`REFRESH_DIV`-1): `cnt`→0 and `idx`→`idx`+1, wrapping 7→0.
- Output during SCAN:
  - `cnt` < `GAP_CYC`: `anode`=8'hFF and `display`=7'h7F.
  - Otherwise: `anode`=~(1<<`idx`) and `display`=hex7(`shown[4*idx+3:4*idx]`).
- hex7 encoding: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110. Remaining digits use standard hex glyphs, with b, d and lower-case where conventional.
- All outputs are registered. There are no combinational paths from inputs to pins.

## Timing
- Reset values: `anode`=8'hFF, `display`=7'h7F, `dp`=1, `frame_start`=0, `shadow`=`shown`=0, `cnt`=0, `idx`=0, state IDLE.
- `rst` asserted mid-scan: outputs reach reset values on the next edge. Any pending shadow value is discarded.
- First load at edge T:
  - Digit 0 enters its gap at T+1.
  - Digit 0 anode goes low at T+1+`GAP_CYC`.
  - `frame_start` pulses at T+1.
- Later loads appear no sooner than the next frame boundary. The worst-case delay is 8·`REFRESH_DIV` cycles, and a frame never shows a mix of old and new values.
- `frame_start` is high for the cycle in which `idx`=0 and `cnt`=0.
- `hold` is sampled only on the frame-boundary cycle. Asserting it at any other time has no effect until that boundary.

## Configuration
- `SEG_ZERO_BLANK_EN` defined:
  - Leading-zero blanking is on. Digit k is blanked (`display`=7'h7F, anode still driven) when nibbles 7..k of `shown` are all 0 and k≠0.
  - Value 0 shows only digit 0 as "0".
- Not defined: all eight digits always display, including leading zeros.

## Test plan
Run with `REFRESH_DIV`=4 and `GAP_CYC`=1.

1. **Reset and idle.** Hold `rst` 3 cycles, then idle 20 cycles with no load. Required: `anode`=8'hFF, `display`=7'h7F, `dp`=1 throughout.
2. **First load.** Load 32'h0000_00A1. Required:
   - Digit 0 shows 7'b1111001 with anode 8'hFE.
   - Digit 1 shows 7'b0001000 with anode 8'hFD.
   - Each slot has a 1-cycle all-off gap.
   - `frame_start` pulses every 32 cycles.
3. **Frame coherence.** Load 32'h1111_1111, then load 32'hFFFF_FFFF mid-frame. Required: the remaining digits of that frame show "1"; every digit of the next frame shows 7'b0001110.
4. **Boundary bypass and hold.**
   - Load 32'h8888_8888 on the boundary cycle. Required: the next frame shows 7'b0000000.
   - Load a new value while `hold`=1 across a boundary. Required: the displayed value stays unchanged.
5. **Leading-zero blanking.** With `SEG_ZERO_BLANK_EN` defined, load 32'h0000_0000. Required: digits 1–7 show 7'h7F; digit 0 shows 7'b1000000.
6. **Mid-scan reset.** Assert `rst` while `idx`=5. Required: all outputs return to reset values on the next edge, and the block stays in IDLE until a load.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with a frame-coherent shadow/shown register pair.
// Optional leading-zero blanking is enabled by defining SEG_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYC     = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ResultW,
  input  logic        load,
  input  logic        hold,
  output logic [7:0]  anode,
  output logic [6:0]  display,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_shadow, r_shown, w_shown_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic        w_slot_end, w_boundary, w_gap, w_blank;
  logic [3:0]  w_nib;
  logic [6:0]  w_glyph, w_disp_nxt;
  logic [7:0]  w_anode_nxt;
  logic        w_fs_nxt;

  assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_boundary = w_slot_end && (r_idx == 3'd7);
  assign w_gap      = (r_cnt < CW'(GAP_CYC));
  assign w_nib      = r_shown[{r_idx, 2'b00} +: 4];

`ifdef SEG_ZERO_BLANK_EN
  // Blank digit k when it and every digit to its left are zero; digit 0 always shows.
  assign w_blank = (r_idx != 3'd0) && ((r_shown >> {r_idx, 2'b00}) == 32'd0);
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_glyph = 7'h7F;
    unique case (w_nib)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b0000011;
      4'hC: w_glyph = 7'b1000110;
      4'hD: w_glyph = 7'b0100001;
      4'hE: w_glyph = 7'b0000110;
      4'hF: w_glyph = 7'b0001110;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shown_nxt = r_shown;
    w_anode_nxt = 8'hFF;
    w_disp_nxt  = 7'h7F;
    w_fs_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_SCAN;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_shown_nxt = ResultW;
        end
      end
      S_SCAN: begin
        if (w_slot_end) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        // A load on the boundary cycle bypasses the shadow straight into the next frame.
        if (w_boundary && !hold)
          w_shown_nxt = load ? ResultW : r_shadow;
        w_fs_nxt = (r_cnt == '0) && (r_idx == 3'd0);
        if (!w_gap) begin
          w_anode_nxt = ~(8'd1 << r_idx);
          w_disp_nxt  = w_blank ? 7'h7F : w_glyph;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shadow    <= 32'd0;
      r_shown     <= 32'd0;
      anode       <= 8'hFF;
      display     <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shown     <= w_shown_nxt;
      if (load)
        r_shadow  <= ResultW;
      anode       <= w_anode_nxt;
      display     <= w_disp_nxt;
      frame_start <= w_fs_nxt;
    end
  end

  assign dp = 1'b1;

endmodule
